// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard scoreboard: multi-cycle unit FSM states,
// Execute forward-select encodings and the saturating performance-counter helper.
package haz_pkg;

  localparam int PERF_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } mc_state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_MC = 2'b11;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + PERF_W'(1) : v;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side signal bundle of the hazard scoreboard. Performance counter outputs
// exist only when HAZ_PERF_EN is defined.
interface hazard_scoreboard_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 4
);
  logic [ADDR_W-1:0] Ra_D, Rb_D, Ra_E, Rb_E;
  logic [ADDR_W-1:0] WriteReg_E, WriteReg_M, WriteReg_W;
  logic              RegWrite_E, RegWrite_M, RegWrite_W;
  logic              MemToReg_E, MemToReg_M, BranchD, McOp_D;
  logic              McIssue_E;
  logic [ADDR_W-1:0] McDest_E;
  logic [CNT_W-1:0]  McLat_E;

  logic              McWb, McBusy;
  logic [ADDR_W-1:0] McDest;
  logic              StallPC, StallD, FlushE;
  logic [1:0]        F_AE, F_BE;
  logic              F_AD, F_BD;

`ifdef HAZ_PERF_EN
  logic [31:0] PerfLw, PerfBr, PerfSb, PerfStruct;

  modport master (
    output Ra_D, Rb_D, Ra_E, Rb_E, WriteReg_E, WriteReg_M, WriteReg_W,
           RegWrite_E, RegWrite_M, RegWrite_W, MemToReg_E, MemToReg_M,
           BranchD, McOp_D, McIssue_E, McDest_E, McLat_E,
    input  McWb, McDest, McBusy, StallPC, StallD, FlushE, F_AE, F_BE, F_AD, F_BD,
           PerfLw, PerfBr, PerfSb, PerfStruct
  );
  modport slave (
    input  Ra_D, Rb_D, Ra_E, Rb_E, WriteReg_E, WriteReg_M, WriteReg_W,
           RegWrite_E, RegWrite_M, RegWrite_W, MemToReg_E, MemToReg_M,
           BranchD, McOp_D, McIssue_E, McDest_E, McLat_E,
    output McWb, McDest, McBusy, StallPC, StallD, FlushE, F_AE, F_BE, F_AD, F_BD,
           PerfLw, PerfBr, PerfSb, PerfStruct
  );
`else
  modport master (
    output Ra_D, Rb_D, Ra_E, Rb_E, WriteReg_E, WriteReg_M, WriteReg_W,
           RegWrite_E, RegWrite_M, RegWrite_W, MemToReg_E, MemToReg_M,
           BranchD, McOp_D, McIssue_E, McDest_E, McLat_E,
    input  McWb, McDest, McBusy, StallPC, StallD, FlushE, F_AE, F_BE, F_AD, F_BD
  );
  modport slave (
    input  Ra_D, Rb_D, Ra_E, Rb_E, WriteReg_E, WriteReg_M, WriteReg_W,
           RegWrite_E, RegWrite_M, RegWrite_W, MemToReg_E, MemToReg_M,
           BranchD, McOp_D, McIssue_E, McDest_E, McLat_E,
    output McWb, McDest, McBusy, StallPC, StallD, FlushE, F_AE, F_BE, F_AD, F_BD
  );
`endif

endinterface

// File: rtl/hazard_scoreboard_mc_tracker.sv
// Multi-cycle unit tracker: countdown FSM, destination latch and per-register pending bits.
// The write-back pulse lands exactly max(latency,1) cycles after the issue cycle.
module mc_tracker
  import haz_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mc_issue,
  input  logic [ADDR_W-1:0]   issue_dest,
  input  logic [CNT_W-1:0]    issue_lat,
  output logic                mc_wb,
  output logic                busy,
  output logic [ADDR_W-1:0]   mc_dest,
  output logic [NUM_REGS-1:0] pending
);

  mc_state_e           state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next, load_cnt;
  logic [ADDR_W-1:0]   dest_q;
  logic [NUM_REGS-1:0] pend_q, pend_next;
  logic                accept;

  assign load_cnt = (issue_lat == '0) ? '0 : issue_lat - CNT_W'(1);
  // Issues arriving while counting down are dropped; the WB cycle may accept a new op.
  assign accept   = mc_issue && (state != BUSY);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pend_next  = pend_q;
    unique case (state)
      IDLE, WB: begin
        if (accept) begin
          cnt_next   = load_cnt;
          state_next = (load_cnt == '0) ? WB : BUSY;
        end else begin
          state_next = IDLE;
        end
      end
      BUSY: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_next = WB;
      end
      default: state_next = IDLE;
    endcase
    // NOTE: blocking assignments in sequence here, so the set below overrides the clear
    // when a new op targets the register being written back this cycle.
    if (state == WB) pend_next[dest_q] = 1'b0;
    if (accept)      pend_next[issue_dest] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      dest_q <= '0;
      // NOTE: pend_q is a flop vector rather than a RAM, so it can be cleared in one cycle.
      pend_q <= '0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      pend_q <= pend_next;
      if (accept) dest_q <= issue_dest;
    end
  end

  assign mc_wb   = !rst && (state == WB);
  assign busy    = !rst && (state != IDLE);
  assign mc_dest = rst ? '0 : dest_q;
  assign pending = pend_q;

  issue_while_busy: assert property (@(posedge clk) disable iff (rst) !(mc_issue && state == BUSY));

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage pipeline with a multi-cycle MUL/DIV scoreboard.
// Optional HAZ_PERF_EN adds saturating stall-cause counters.
module hazard_scoreboard
  import haz_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 4
) (
  input  logic          clk,
  input  logic          rst,
  hazard_scoreboard_if.slave hif
);

  logic                mc_wb, mc_busy;
  logic [ADDR_W-1:0]   mc_dest;
  logic [NUM_REGS-1:0] pending;
  logic                lw_stall, br_stall, sb_stall, st_stall, stall;
  logic [1:0]          fae, fbe;
  logic                fad, fbd;

  mc_tracker #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .CNT_W(CNT_W)) u_mc (
    .clk        (clk),
    .rst        (rst),
    .mc_issue   (hif.McIssue_E),
    .issue_dest (hif.McDest_E),
    .issue_lat  (hif.McLat_E),
    .mc_wb      (mc_wb),
    .busy       (mc_busy),
    .mc_dest    (mc_dest),
    .pending    (pending)
  );

  function automatic logic hit(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  // A source whose result is being written back this cycle no longer needs to wait.
  function automatic logic src_wait(input logic [ADDR_W-1:0] r, input logic [NUM_REGS-1:0] pend,
                                    input logic wb, input logic [ADDR_W-1:0] wb_dest);
    return (r != '0) && pend[r] && !(wb && (wb_dest == r));
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [ADDR_W-1:0] r,
                                         input logic rw_m, input logic [ADDR_W-1:0] wr_m,
                                         input logic wb, input logic [ADDR_W-1:0] wb_dest,
                                         input logic rw_w, input logic [ADDR_W-1:0] wr_w);
    if (rw_m && hit(wr_m, r))  return FWD_M;
    if (wb && hit(wb_dest, r)) return FWD_MC;
    if (rw_w && hit(wr_w, r))  return FWD_W;
    return FWD_RF;
  endfunction

  always_comb begin
    lw_stall = 1'b0;
    br_stall = 1'b0;
    sb_stall = 1'b0;
    st_stall = 1'b0;
    fae      = FWD_RF;
    fbe      = FWD_RF;
    fad      = 1'b0;
    fbd      = 1'b0;
    if (!rst) begin
      lw_stall = hif.MemToReg_E && hif.RegWrite_E &&
                 (hit(hif.WriteReg_E, hif.Ra_D) || hit(hif.WriteReg_E, hif.Rb_D));
      br_stall = hif.BranchD &&
                 ((hif.RegWrite_E && (hit(hif.WriteReg_E, hif.Ra_D) || hit(hif.WriteReg_E, hif.Rb_D))) ||
                  (hif.MemToReg_M && (hit(hif.WriteReg_M, hif.Ra_D) || hit(hif.WriteReg_M, hif.Rb_D))));
      sb_stall = src_wait(hif.Ra_D, pending, mc_wb, mc_dest) ||
                 src_wait(hif.Rb_D, pending, mc_wb, mc_dest);
      st_stall = hif.McOp_D && mc_busy && !mc_wb;
      fae = fwd_sel(hif.Ra_E, hif.RegWrite_M, hif.WriteReg_M, mc_wb, mc_dest,
                    hif.RegWrite_W, hif.WriteReg_W);
      fbe = fwd_sel(hif.Rb_E, hif.RegWrite_M, hif.WriteReg_M, mc_wb, mc_dest,
                    hif.RegWrite_W, hif.WriteReg_W);
      fad = hif.RegWrite_M && hit(hif.WriteReg_M, hif.Ra_D);
      fbd = hif.RegWrite_M && hit(hif.WriteReg_M, hif.Rb_D);
    end
  end

  assign stall       = lw_stall || br_stall || sb_stall || st_stall;
  assign hif.StallPC = stall;
  assign hif.StallD  = stall;
  assign hif.FlushE  = stall;
  assign hif.F_AE    = fae;
  assign hif.F_BE    = fbe;
  assign hif.F_AD    = fad;
  assign hif.F_BD    = fbd;
  assign hif.McWb    = mc_wb;
  assign hif.McBusy  = mc_busy;
  assign hif.McDest  = mc_dest;

`ifdef HAZ_PERF_EN
  logic [PERF_W-1:0] perf_lw, perf_br, perf_sb, perf_st;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lw <= '0;
      perf_br <= '0;
      perf_sb <= '0;
      perf_st <= '0;
    end else begin
      perf_lw <= sat_inc(perf_lw, lw_stall);
      perf_br <= sat_inc(perf_br, br_stall);
      perf_sb <= sat_inc(perf_sb, sb_stall);
      perf_st <= sat_inc(perf_st, st_stall);
    end
  end

  assign hif.PerfLw     = perf_lw;
  assign hif.PerfBr     = perf_br;
  assign hif.PerfSb     = perf_sb;
  assign hif.PerfStruct = perf_st;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized traffic
// compared against an issue-time/write-back-time reference model.
module tb_hazard_scoreboard;
  import haz_pkg::*;

  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int CNT_W    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) hif ();

  hazard_scoreboard #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: an in-flight op is just "which register, and at which cycle it retires".
  bit      m_busy;
  int      m_wb_at;
  int      m_dest;
  bit      m_pend[NUM_REGS];
  longint  m_perf[4];

  bit       e_wb, e_lw, e_br, e_sb, e_st, e_stall, e_fad, e_fbd;
  bit [1:0] e_fae, e_fbe;

  function automatic bit hit(int a, int b);
    return (a != 0) && (a == b);
  endfunction

  function automatic bit src_wait(int r);
    return (r != 0) && m_pend[r] && !(e_wb && (m_dest == r));
  endfunction

  function automatic bit [1:0] fwd(int r);
    if (hif.RegWrite_M && hit(hif.WriteReg_M, r)) return 2'b10;
    if (e_wb && hit(m_dest, r))                   return 2'b11;
    if (hif.RegWrite_W && hit(hif.WriteReg_W, r)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic eval();
    int ra, rb, we, wm;
    ra = hif.Ra_D; rb = hif.Rb_D; we = hif.WriteReg_E; wm = hif.WriteReg_M;
    e_wb    = m_busy && (cyc == m_wb_at);
    e_lw    = hif.MemToReg_E && hif.RegWrite_E && (hit(we, ra) || hit(we, rb));
    e_br    = hif.BranchD && ((hif.RegWrite_E && (hit(we, ra) || hit(we, rb))) ||
                              (hif.MemToReg_M && (hit(wm, ra) || hit(wm, rb))));
    e_sb    = src_wait(ra) || src_wait(rb);
    e_st    = hif.McOp_D && m_busy && !e_wb;
    e_stall = e_lw || e_br || e_sb || e_st;
    e_fae   = fwd(hif.Ra_E);
    e_fbe   = fwd(hif.Rb_E);
    e_fad   = hif.RegWrite_M && hit(wm, ra);
    e_fbd   = hif.RegWrite_M && hit(wm, rb);
  endtask

  task automatic model_update();
    int lat;
    if (rst) begin
      m_busy = 0; m_dest = 0;
      foreach (m_pend[i]) m_pend[i] = 0;
      foreach (m_perf[i]) m_perf[i] = 0;
    end else begin
      eval();
      m_perf[0] += e_lw; m_perf[1] += e_br; m_perf[2] += e_sb; m_perf[3] += e_st;
      if (e_wb) begin
        m_pend[m_dest] = 0;
        m_busy = 0;
      end
      if (hif.McIssue_E && !m_busy) begin
        lat = (hif.McLat_E == 0) ? 1 : int'(hif.McLat_E);
        m_busy  = 1;
        m_dest  = hif.McDest_E;
        m_wb_at = cyc + lat;
        m_pend[m_dest] = 1;
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive_idle();
    hif.Ra_D = '0; hif.Rb_D = '0; hif.Ra_E = '0; hif.Rb_E = '0;
    hif.WriteReg_E = '0; hif.WriteReg_M = '0; hif.WriteReg_W = '0;
    hif.RegWrite_E = 0; hif.RegWrite_M = 0; hif.RegWrite_W = 0;
    hif.MemToReg_E = 0; hif.MemToReg_M = 0; hif.BranchD = 0; hif.McOp_D = 0;
    hif.McIssue_E = 0; hif.McDest_E = '0; hif.McLat_E = '0;
  endtask

  task automatic test_reset();
    rst = 1;
    drive_idle();
    hif.MemToReg_E = 1; hif.RegWrite_E = 1; hif.WriteReg_E = 5'd8; hif.Ra_D = 5'd8;
    hif.RegWrite_M = 1; hif.WriteReg_M = 5'd8; hif.Ra_E = 5'd8;
    tick();
    @(negedge clk);
    checks++;
    if (hif.StallPC !== 1'b0 || hif.F_AE !== 2'b00 || hif.F_AD !== 1'b0) begin
      errors++;
      $display("FAIL reset_forced_comb stall=%b fae=%b fad=%b exp 0/00/0", hif.StallPC, hif.F_AE, hif.F_AD);
    end
    tick();
    rst = 0;
    drive_idle();
    @(negedge clk);
    checks++;
    if (hif.McBusy !== 1'b0 || hif.McWb !== 1'b0 || hif.McDest !== 5'd0) begin
      errors++;
      $display("FAIL reset_state busy=%b wb=%b dest=%0d exp 0/0/0", hif.McBusy, hif.McWb, hif.McDest);
    end
    tick();
  endtask

  task automatic test_load_use();
    drive_idle();
    hif.MemToReg_E = 1; hif.RegWrite_E = 1; hif.WriteReg_E = 5'd8; hif.Ra_D = 5'd8;
    @(negedge clk);
    checks++;
    if ({hif.StallPC, hif.StallD, hif.FlushE} !== 3'b111) begin
      errors++;
      $display("FAIL load_use_stall got %b exp 111", {hif.StallPC, hif.StallD, hif.FlushE});
    end
    tick();
    drive_idle();
    hif.RegWrite_M = 1; hif.MemToReg_M = 1; hif.WriteReg_M = 5'd8; hif.Ra_E = 5'd8;
    @(negedge clk);
    checks++;
    if (hif.F_AE !== 2'b10 || hif.StallPC !== 1'b0) begin
      errors++;
      $display("FAIL load_use_fwd fae=%b stall=%b exp 10/0", hif.F_AE, hif.StallPC);
    end
    // Register 0 never matches.
    hif.WriteReg_M = 5'd0; hif.Ra_E = 5'd0; hif.Ra_D = 5'd0;
    @(negedge clk);
    checks++;
    if (hif.F_AE !== 2'b00 || hif.F_AD !== 1'b0) begin
      errors++;
      $display("FAIL reg0_no_fwd fae=%b fad=%b exp 00/0", hif.F_AE, hif.F_AD);
    end
    tick();
  endtask

  task automatic test_mc_latency();
    drive_idle();
    hif.McIssue_E = 1; hif.McDest_E = 5'd5; hif.McLat_E = 4'd4; hif.Rb_D = 5'd5;
    @(negedge clk);
    checks++;
    if (hif.McBusy !== 1'b0 || hif.StallD !== 1'b0) begin
      errors++;
      $display("FAIL mc_issue_cycle busy=%b stall=%b exp 0/0", hif.McBusy, hif.StallD);
    end
    tick();
    hif.McIssue_E = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (hif.McBusy !== 1'b1 || hif.McWb !== 1'b0 || hif.StallD !== 1'b1) begin
        errors++;
        $display("FAIL mc_wait k=%0d busy=%b wb=%b stall=%b exp 1/0/1", k, hif.McBusy, hif.McWb, hif.StallD);
      end
      tick();
    end
    hif.Rb_E = 5'd5;
    @(negedge clk);
    checks++;
    if (hif.McWb !== 1'b1 || hif.F_BE !== 2'b11 || hif.StallD !== 1'b0 || hif.McDest !== 5'd5) begin
      errors++;
      $display("FAIL mc_wb_cycle wb=%b fbe=%b stall=%b dest=%0d exp 1/11/0/5", hif.McWb, hif.F_BE, hif.StallD, hif.McDest);
    end
    tick();
    @(negedge clk);
    checks++;
    if (hif.McBusy !== 1'b0 || hif.McWb !== 1'b0 || hif.StallD !== 1'b0) begin
      errors++;
      $display("FAIL mc_after_wb busy=%b wb=%b stall=%b exp 0/0/0", hif.McBusy, hif.McWb, hif.StallD);
    end
    tick();
  endtask

  task automatic test_lat_zero();
    drive_idle();
    hif.McIssue_E = 1; hif.McDest_E = 5'd7; hif.McLat_E = 4'd0;
    tick();
    hif.McIssue_E = 0;
    @(negedge clk);
    checks++;
    if (hif.McWb !== 1'b1 || hif.McDest !== 5'd7) begin
      errors++;
      $display("FAIL lat_zero_wb wb=%b dest=%0d exp 1/7", hif.McWb, hif.McDest);
    end
    tick();
    @(negedge clk);
    checks++;
    if (hif.McBusy !== 1'b0) begin
      errors++;
      $display("FAIL lat_zero_idle busy=%b exp 0", hif.McBusy);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    drive_idle();
    hif.McIssue_E = 1; hif.McDest_E = 5'd3; hif.McLat_E = 4'd1;
    tick();
    hif.McLat_E = 4'd2; hif.Ra_D = 5'd3;
    @(negedge clk);
    checks++;
    if (hif.McWb !== 1'b1 || hif.StallD !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first_wb wb=%b stall=%b exp 1/0", hif.McWb, hif.StallD);
    end
    tick();
    hif.McIssue_E = 0;
    @(negedge clk);
    checks++;
    if (hif.McBusy !== 1'b1 || hif.McWb !== 1'b0 || hif.StallD !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pending_kept busy=%b wb=%b stall=%b exp 1/0/1", hif.McBusy, hif.McWb, hif.StallD);
    end
    tick();
    @(negedge clk);
    checks++;
    if (hif.McWb !== 1'b1 || hif.McDest !== 5'd3) begin
      errors++;
      $display("FAIL b2b_second_wb wb=%b dest=%0d exp 1/3", hif.McWb, hif.McDest);
    end
    tick();
    @(negedge clk);
    checks++;
    if (hif.McBusy !== 1'b0 || hif.StallD !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done busy=%b stall=%b exp 0/0", hif.McBusy, hif.StallD);
    end
    tick();
  endtask

  task automatic test_struct();
    drive_idle();
    hif.McIssue_E = 1; hif.McDest_E = 5'd9; hif.McLat_E = 4'd3;
    tick();
    hif.McIssue_E = 0; hif.McOp_D = 1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (hif.StallPC !== ((k <= 2) ? 1'b1 : 1'b0) || hif.McWb !== ((k == 3) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL struct_stall k=%0d stall=%b wb=%b exp %b/%b", k, hif.StallPC, hif.McWb,
                 (k <= 2) ? 1'b1 : 1'b0, (k == 3) ? 1'b1 : 1'b0);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    drive_idle();
    hif.McIssue_E = 1; hif.McDest_E = 5'd12; hif.McLat_E = 4'd10;
    tick();
    hif.McIssue_E = 0;
    tick();
    @(negedge clk);
    checks++;
    if (hif.McBusy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy_before_rst busy=%b exp 1", hif.McBusy);
    end
    rst = 1; hif.Ra_D = 5'd12;
    tick();
    rst = 0;
    @(negedge clk);
`ifdef HAZ_PERF_EN
    checks++;
    if (hif.PerfLw !== 32'd0 || hif.PerfBr !== 32'd0 || hif.PerfSb !== 32'd0 || hif.PerfStruct !== 32'd0) begin
      errors++;
      $display("FAIL mid_perf_cleared got %0d %0d %0d %0d exp 0", hif.PerfLw, hif.PerfBr, hif.PerfSb, hif.PerfStruct);
    end
`endif
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (hif.McBusy !== 1'b0 || hif.McWb !== 1'b0 || hif.StallD !== 1'b0) begin
        errors++;
        $display("FAIL mid_rst_quiet k=%0d busy=%b wb=%b stall=%b exp 0/0/0", k, hif.McBusy, hif.McWb, hif.StallD);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      hif.Ra_D = 5'($urandom_range(0, 7)); hif.Rb_D = 5'($urandom_range(0, 7));
      hif.Ra_E = 5'($urandom_range(0, 7)); hif.Rb_E = 5'($urandom_range(0, 7));
      hif.WriteReg_E = 5'($urandom_range(0, 7));
      hif.WriteReg_M = 5'($urandom_range(0, 7));
      hif.WriteReg_W = 5'($urandom_range(0, 7));
      hif.RegWrite_E = 1'($urandom_range(0, 1)); hif.RegWrite_M = 1'($urandom_range(0, 1));
      hif.RegWrite_W = 1'($urandom_range(0, 1)); hif.MemToReg_E = 1'($urandom_range(0, 1));
      hif.MemToReg_M = 1'($urandom_range(0, 1)); hif.BranchD = 1'($urandom_range(0, 1));
      hif.McOp_D = 1'($urandom_range(0, 1));
      hif.McIssue_E = (!m_busy || cyc == m_wb_at) && ($urandom_range(0, 2) == 0);
      hif.McDest_E = 5'($urandom_range(0, 7));
      hif.McLat_E = 4'($urandom_range(0, 6));
      @(negedge clk);
      eval();
      checks++;
      if ({hif.StallPC, hif.StallD, hif.FlushE} !== {3{e_stall}}) begin
        errors++;
        $display("FAIL rand_stall n=%0d got %b exp %b", n, {hif.StallPC, hif.StallD, hif.FlushE}, {3{e_stall}});
      end
      checks++;
      if (hif.F_AE !== e_fae || hif.F_BE !== e_fbe) begin
        errors++;
        $display("FAIL rand_fwd_e n=%0d got %b/%b exp %b/%b", n, hif.F_AE, hif.F_BE, e_fae, e_fbe);
      end
      checks++;
      if (hif.F_AD !== e_fad || hif.F_BD !== e_fbd) begin
        errors++;
        $display("FAIL rand_fwd_d n=%0d got %b/%b exp %b/%b", n, hif.F_AD, hif.F_BD, e_fad, e_fbd);
      end
      checks++;
      if (hif.McWb !== e_wb || hif.McBusy !== m_busy || hif.McDest !== 5'(m_dest)) begin
        errors++;
        $display("FAIL rand_mc n=%0d wb=%b busy=%b dest=%0d exp %b/%b/%0d",
                 n, hif.McWb, hif.McBusy, hif.McDest, e_wb, m_busy, m_dest);
      end
`ifdef HAZ_PERF_EN
      checks++;
      if (hif.PerfLw !== 32'(m_perf[0]) || hif.PerfBr !== 32'(m_perf[1]) ||
          hif.PerfSb !== 32'(m_perf[2]) || hif.PerfStruct !== 32'(m_perf[3])) begin
        errors++;
        $display("FAIL rand_perf n=%0d got %0d %0d %0d %0d exp %0d %0d %0d %0d", n,
                 hif.PerfLw, hif.PerfBr, hif.PerfSb, hif.PerfStruct,
                 m_perf[0], m_perf[1], m_perf[2], m_perf[3]);
      end
`endif
      tick();
    end
  endtask

  initial begin
    rst = 1;
    drive_idle();
    test_reset();
    test_load_use();
    test_mc_latency();
    test_lat_zero();
    test_back_to_back();
    test_struct();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Next-generation hazard unit for the 5-stage MIPS pipeline. Adds a variable-latency multi-cycle execution unit (MUL/DIV) alongside the existing ALU/load path.
- Combines the classic load-use and branch stall/forward logic with a per-register pending scoreboard and a countdown FSM for the multi-cycle unit.
- Sits beside the datapath and drives the stall, flush and forward-select controls for the F, D and E stages.

Parameters:
ADDR_W, 5, register-address width
NUM_REGS, 32, architectural register count (2**ADDR_W)
CNT_W, 4, latency counter width; maximum latency is 2**CNT_W-1

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous active-high reset
Ra_D, Rb_D  in  ADDR_W  source registers in Decode
Ra_E, Rb_E  in  ADDR_W  source registers in Execute
WriteReg_E, WriteReg_M, WriteReg_W  in  ADDR_W  destination register per stage
RegWrite_E, RegWrite_M, RegWrite_W  in  1  write-enable per stage
MemToReg_E, MemToReg_M  in  1  load in E / load in M
BranchD  in  1  branch in Decode
McOp_D  in  1  Decode holds a multi-cycle op
McIssue_E  in  1  multi-cycle op leaving Execute this cycle
McDest_E  in  ADDR_W  its destination register
McLat_E  in  CNT_W  its latency in cycles
McWb  out  1  multi-cycle result written back this cycle (one-cycle pulse)
McDest  out  ADDR_W  destination of the in-flight op
McBusy  out  1  multi-cycle unit occupied
StallPC, StallD, FlushE  out  1  pipeline controls
F_AE, F_BE  out  2  Execute operand select: 00 RF, 01 W, 10 M, 11 MC result
F_AD, F_BD  out  1  Decode branch-compare forward from M

Behaviour:
- Register 0 never matches in any stall or forward comparison.
- lwstall = MemToReg_E && RegWrite_E && (WriteReg_E==Ra_D || WriteReg_E==Rb_D).
- branchstall = BranchD && ((RegWrite_E && WriteReg_E hits Ra_D/Rb_D) || (MemToReg_M && WriteReg_M hits Ra_D/Rb_D)).
- sbstall = pending[Ra_D] || pending[Rb_D], excluding a register whose McWb pulse occurs this cycle.
- structstall = McOp_D && McBusy && !McWb.
- StallPC = StallD = FlushE = OR of all four stall terms. All stall outputs are combinational and same-cycle.
- F_AE/F_BE priority: M (10) > McWb with McDest match (11) > W (01) > 00.
- F_AD/F_BD = RegWrite_M && WriteReg_M!=0 && WriteReg_M matches Ra_D/Rb_D.
- FSM states: IDLE, BUSY, WB.
  - IDLE -> BUSY on McIssue_E: load cnt = max(McLat_E,1)-1, latch McDest, set pending[McDest_E].
  - BUSY: cnt decrements each cycle; when cnt==0, go to WB.
  - WB: assert McWb and clear pending[McDest]. Go to BUSY if McIssue_E is also high this cycle, else IDLE.
- Latency rule: McWb fires exactly max(McLat_E,1) cycles after the issue cycle.
- McBusy = (state != IDLE).
- McIssue_E in BUSY before WB is a protocol violation: ignored, and an assertion fires in simulation.
- Simultaneous clear and set of the same register in WB: set wins, so pending stays 1.
- Reset, including mid-operation: next edge gives state IDLE, cnt=0, pending all 0, McDest=0, McWb=0. Combinational outputs are forced to 0 while rst is high.

Optional Feature:
HAZ_PERF_EN
- Compiled in: adds 32-bit saturating counters PerfLw, PerfBr, PerfSb, PerfStruct as outputs. Each counts cycles in which its stall term is asserted. All reset to 0 and hold at 32'hFFFF_FFFF.
- Compiled out: no counter ports or logic; all other behaviour is identical.

Decomposition:
- Package haz_pkg: FSM state enum (IDLE, BUSY, WB) and forward-select constants FWD_RF, FWD_W, FWD_M, FWD_MC.
- Sub-module mc_tracker: holds the FSM, latency counter and pending vector. Exports McBusy, McWb, McDest and the pending vector.
- Top level: all combinational stall and forward logic.

Test Plan:
- lw $8 in E (MemToReg_E=1, WriteReg_E=8), Ra_D=8 -> StallPC=StallD=FlushE=1 for one cycle; next cycle, with the load in M, F_AE=10.
- McIssue_E, McDest_E=5, McLat_E=4 -> McBusy=1, McWb pulses exactly 4 cycles later; Rb_D=5 stalls every cycle until the McWb cycle, and F_BE=11 on the McWb cycle when Rb_E=5.
- McLat_E=0 -> treated as 1: McWb on the next cycle.
- McWb for $3 with McIssue_E (dest $3, lat 2) in the same cycle -> pending[3] stays 1, state goes to BUSY, second McWb 2 cycles later.
- McOp_D=1 while BUSY -> structstall=1; on the McWb cycle structstall=0.
- rst asserted mid-BUSY -> next cycle McBusy=0, pending all 0, no McWb pulse; with HAZ_PERF_EN defined, counters read 0.
